// File: rtl/i2c_pkg.sv
// Shared types and constants for the byte-level I2C write master.
// Holds the FSM encoding, quarter-phase names and the bus drive decode.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START_C = 3'd1,
        BIT     = 3'd2,
        ACK     = 3'd3,
        STOP_C  = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam int BYTES_PER_WRITE = 3;
    localparam int BITS_PER_BYTE   = 8;
    localparam int DEFAULT_CLK_DIV = 250;

    // Returns {scl_oe, sda_oe} for a given state/quarter; 1 means pull the line low.
    function automatic logic [1:0] bus_drive(input state_t st, input logic [1:0] q,
                                             input logic tx_bit);
        logic scl_pull;
        logic sda_pull;
        scl_pull = 1'b0;
        sda_pull = 1'b0;
        case (st)
            START_C: begin
                sda_pull = 1'b1;
                scl_pull = (q == Q1);
            end
            BIT, ACK: begin
                scl_pull = (q == Q0) || (q == Q3);
                sda_pull = (st == BIT) ? ~tx_bit : 1'b0;
            end
            STOP_C: begin
                scl_pull = (q == Q0);
                sda_pull = (q == Q0) || (q == Q1);
            end
            default: ;
        endcase
        return {scl_pull, sda_pull};
    endfunction

endpackage

// File: rtl/i2c_write_master_quarter_tick.sv
// Quarter-period divider: one-cycle tick every CLK_DIV cycles while en is high.
// Latency: first tick CLK_DIV cycles after en rises; counter held at 0 while en is low.
module i2c_quarter_tick
    import i2c_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    logic [15:0] cnt;

    assign tick = en && (cnt == 16'(CLK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 16'd0;
        end else if (!en || tick) begin
            cnt <= 16'd0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/i2c_write_master.sv
// Single-register I2C write master (START, 3 bytes, STOP) on open-drain SCL/SDA.
// Latency: done 114*CLK_DIV+1 cycles after accept (shorter on NACK); start ignored while busy.
module i2c_write_master
    import i2c_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] device_addr,
    input  logic [7:0] reg_addr,
    input  logic [7:0] reg_data,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       sda_i
);

    localparam int SHW = BYTES_PER_WRITE * BITS_PER_BYTE;

    state_t           state, state_nxt;
    logic [1:0]       qtr, qtr_nxt;
    logic [2:0]       bit_cnt, bit_nxt;
    logic [1:0]       byte_cnt, byte_nxt;
    logic [SHW-1:0]   shreg, sh_nxt;
    logic             ack_err_nxt, busy_nxt, done_nxt;
    logic [1:0]       drive_nxt;
    logic             sda_meta, sda_sync;
    logic             tick, tick_en;

    assign tick_en = (state == START_C) || (state == BIT) ||
                     (state == ACK)     || (state == STOP_C);

    i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) u_quarter_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (tick_en),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sda_meta <= 1'b1;
            sda_sync <= 1'b1;
        end else begin
            sda_meta <= sda_i;
            sda_sync <= sda_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            qtr      <= Q0;
            bit_cnt  <= 3'd0;
            byte_cnt <= 2'd0;
            shreg    <= '0;
            ack_err  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            scl_oe   <= 1'b0;
            sda_oe   <= 1'b0;
        end else begin
            state    <= state_nxt;
            qtr      <= qtr_nxt;
            bit_cnt  <= bit_nxt;
            byte_cnt <= byte_nxt;
            shreg    <= sh_nxt;
            ack_err  <= ack_err_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            scl_oe   <= drive_nxt[1];
            sda_oe   <= drive_nxt[0];
        end
    end

    // Bus outputs are decoded from the next state so the pins come straight off flops.
    always_comb begin
        state_nxt   = state;
        qtr_nxt     = qtr;
        bit_nxt     = bit_cnt;
        byte_nxt    = byte_cnt;
        sh_nxt      = shreg;
        ack_err_nxt = ack_err;

        case (state)
            IDLE: begin
                if (start) begin
                    sh_nxt      = {device_addr, reg_addr, reg_data};
                    ack_err_nxt = 1'b0;
                    state_nxt   = START_C;
                    qtr_nxt     = Q0;
                    bit_nxt     = 3'd0;
                    byte_nxt    = 2'd0;
                end
            end
            START_C: begin
                if (tick) begin
                    if (qtr == Q1) begin
                        state_nxt = BIT;
                        qtr_nxt   = Q0;
                    end else begin
                        qtr_nxt = qtr + 2'd1;
                    end
                end
            end
            BIT: begin
                if (tick) begin
                    if (qtr == Q3) begin
                        qtr_nxt = Q0;
                        sh_nxt  = {shreg[SHW-2:0], 1'b0};
                        if (bit_cnt == 3'(BITS_PER_BYTE - 1)) begin
                            state_nxt = ACK;
                            bit_nxt   = 3'd0;
                        end else begin
                            bit_nxt = bit_cnt + 3'd1;
                        end
                    end else begin
                        qtr_nxt = qtr + 2'd1;
                    end
                end
            end
            ACK: begin
                if (tick) begin
                    if (qtr == Q2 && sda_sync) begin
                        ack_err_nxt = 1'b1;
                    end
                    if (qtr == Q3) begin
                        qtr_nxt = Q0;
                        // ack_err can only have been set by this slot, so it marks a NACK abort.
                        if (ack_err || byte_cnt == 2'(BYTES_PER_WRITE - 1)) begin
                            state_nxt = STOP_C;
                        end else begin
                            state_nxt = BIT;
                            byte_nxt  = byte_cnt + 2'd1;
                        end
                    end else begin
                        qtr_nxt = qtr + 2'd1;
                    end
                end
            end
            STOP_C: begin
                if (tick) begin
                    if (qtr == Q3) begin
                        state_nxt = DONE;
                        qtr_nxt   = Q0;
                    end else begin
                        qtr_nxt = qtr + 2'd1;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt  = (state_nxt != IDLE);
        done_nxt  = (state_nxt == DONE);
        drive_nxt = bus_drive(state_nxt, qtr_nxt, sh_nxt[SHW-1]);
    end

endmodule

// File: tb/tb_i2c_write_master.sv
// Bench for i2c_write_master: open-drain bus model with an ACK/NACK slave and wire decoder.
module tb_i2c_write_master;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] device_addr = 8'h00;
    logic [7:0] reg_addr = 8'h00;
    logic [7:0] reg_data = 8'h00;
    logic       busy, done, ack_err, scl_oe, sda_oe;
    logic       sda_i;

    int total = 0;
    int bad = 0;

    // Bus model state; the monitor is the only writer of these.
    logic       slave_pull = 1'b0;
    logic       mon_prev_scl = 1'b1;
    logic       mon_prev_sda = 1'b1;
    logic       mon_scl, mon_sda;
    logic [7:0] mon_sh = 8'h00;
    int         mon_bits = 0;
    int         mon_byte_idx = 0;
    int         wire_log[$];
    int         nack_byte = -1;

    always #5 clk = ~clk;

    assign sda_i = ~(sda_oe | slave_pull);

    i2c_write_master #(.CLK_DIV(D)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .device_addr (device_addr),
        .reg_addr    (reg_addr),
        .reg_data    (reg_data),
        .busy        (busy),
        .done        (done),
        .ack_err     (ack_err),
        .scl_oe      (scl_oe),
        .sda_oe      (sda_oe),
        .sda_i       (sda_i)
    );

    // Wire decoder: START=0x100, STOP=0x101, otherwise the byte clocked on SCL rising edges.
    always @(negedge clk) begin
        if (rst) begin
            slave_pull   = 1'b0;
            mon_bits     = 0;
            mon_byte_idx = 0;
            mon_prev_scl = 1'b1;
            mon_prev_sda = 1'b1;
        end else begin
            mon_scl = ~scl_oe;
            mon_sda = sda_i;
            if (mon_prev_scl && mon_scl && mon_prev_sda && !mon_sda) begin
                wire_log.push_back(32'h100);
                mon_bits     = 0;
                mon_byte_idx = 0;
            end else if (mon_prev_scl && mon_scl && !mon_prev_sda && mon_sda) begin
                wire_log.push_back(32'h101);
            end else if (!mon_prev_scl && mon_scl) begin
                if (mon_bits < 8) mon_sh = {mon_sh[6:0], mon_sda};
                mon_bits++;
                if (mon_bits == 9) begin
                    wire_log.push_back(int'(mon_sh));
                    mon_bits = 0;
                    mon_byte_idx++;
                end
            end else if (mon_prev_scl && !mon_scl) begin
                if (mon_bits == 8 && mon_byte_idx != nack_byte) slave_pull = 1'b1;
                else if (mon_bits == 0) slave_pull = 1'b0;
            end
            mon_prev_scl = mon_scl;
            mon_prev_sda = mon_sda;
        end
    end

    // Reference: the frame a write should put on the wire and its done latency in cycles.
    function automatic void model_frame(input logic [7:0] dev, input logic [7:0] rg,
                                        input logic [7:0] dat, input int nack,
                                        output logic [63:0] sig, output int n, output int cyc);
        logic [7:0] b [3];
        b[0] = dev;
        b[1] = rg;
        b[2] = dat;
        sig = 64'h100;
        n = 1;
        for (int i = 0; i < 3; i++) begin
            sig = (sig << 12) | 64'(b[i]);
            n++;
            if (i == nack) break;
        end
        sig = (sig << 12) | 64'h101;
        n++;
        cyc = ((nack < 0) ? 114 : 2 + (nack + 1) * 36 + 4) * D + 1;
    endfunction

    // Issues one write and gathers what was observed; comparisons live in the test tasks.
    task automatic do_write(input logic [7:0] dev, input logic [7:0] rg, input logic [7:0] dat,
                            input int nack, input bit mid_start,
                            output int lat, output int busy_cyc, output int dones,
                            output logic ae_acc, output logic ae_end,
                            output logic [63:0] sig, output int n);
        int base;
        int waited;
        waited = 0;
        while (busy !== 1'b0 && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        nack_byte = nack;
        @(negedge clk);
        base = wire_log.size();
        device_addr = dev;
        reg_addr = rg;
        reg_data = dat;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        device_addr = 8'($urandom);
        reg_addr = 8'($urandom);
        reg_data = 8'($urandom);
        ae_acc = ack_err;
        lat = -1;
        busy_cyc = 0;
        dones = 0;
        for (int off = 1; off < 3000; off++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cyc++;
            if (done === 1'b1) begin
                dones++;
                if (lat < 0) lat = off;
            end
            if (mid_start && off == 150) begin
                device_addr = 8'($urandom);
                reg_addr = 8'($urandom);
                reg_data = 8'($urandom);
                start = 1'b1;
            end
            if (off == 151) start = 1'b0;
            if (lat >= 0 && off >= lat + 12) break;
        end
        ae_end = ack_err;
        sig = 64'h0;
        n = 0;
        for (int i = base; i < wire_log.size(); i++) begin
            sig = (sig << 12) | 64'(wire_log[i]);
            n++;
        end
    endtask

    task automatic test_reset();
        #2;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (ack_err !== 1'b0) begin bad++; $display("FAIL reset_ack_err: got %b want 0", ack_err); end
        total++; if (scl_oe !== 1'b0) begin bad++; $display("FAIL reset_scl_oe: got %b want 0", scl_oe); end
        total++; if (sda_oe !== 1'b0) begin bad++; $display("FAIL reset_sda_oe: got %b want 0", sda_oe); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b want 0", busy); end
        total++; if (scl_oe !== 1'b0 || sda_oe !== 1'b0) begin
            bad++; $display("FAIL idle_bus: got scl_oe=%b sda_oe=%b want 0 0", scl_oe, sda_oe);
        end
    endtask

    task automatic test_write_path();
        int lat, bc, dn, n, en, ecyc;
        logic aa, ae;
        logic [63:0] sig, esig;
        do_write(8'h6E, 8'h40, 8'h00, -1, 1'b0, lat, bc, dn, aa, ae, sig, n);
        model_frame(8'h6E, 8'h40, 8'h00, -1, esig, en, ecyc);
        total++; if (lat !== ecyc) begin bad++; $display("FAIL write_latency: got %0d want %0d", lat, ecyc); end
        total++; if (bc !== ecyc) begin bad++; $display("FAIL write_busy_cycles: got %0d want %0d", bc, ecyc); end
        total++; if (dn !== 1) begin bad++; $display("FAIL write_done_count: got %0d want 1", dn); end
        total++; if (ae !== 1'b0) begin bad++; $display("FAIL write_ack_err: got %b want 0", ae); end
        total++; if (sig !== esig || n !== en) begin
            bad++; $display("FAIL write_wire: got %h/%0d want %h/%0d", sig, n, esig, en);
        end
    endtask

    task automatic test_device_nack();
        int lat, bc, dn, n, en, ecyc;
        logic aa, ae;
        logic [63:0] sig, esig;
        do_write(8'h6E, 8'h30, 8'h30, 0, 1'b0, lat, bc, dn, aa, ae, sig, n);
        model_frame(8'h6E, 8'h30, 8'h30, 0, esig, en, ecyc);
        total++; if (lat !== ecyc) begin bad++; $display("FAIL dev_nack_latency: got %0d want %0d", lat, ecyc); end
        total++; if (ae !== 1'b1) begin bad++; $display("FAIL dev_nack_ack_err: got %b want 1", ae); end
        total++; if (sig !== esig || n !== en) begin
            bad++; $display("FAIL dev_nack_wire: got %h/%0d want %h/%0d", sig, n, esig, en);
        end
    endtask

    task automatic test_data_nack();
        int lat, bc, dn, n, en, ecyc;
        logic aa, ae;
        logic [63:0] sig, esig;
        logic [7:0] d0, d1, d2;
        d0 = 8'($urandom); d1 = 8'($urandom); d2 = 8'($urandom);
        do_write(d0, d1, d2, 2, 1'b0, lat, bc, dn, aa, ae, sig, n);
        model_frame(d0, d1, d2, 2, esig, en, ecyc);
        total++; if (lat !== ecyc) begin bad++; $display("FAIL data_nack_latency: got %0d want %0d", lat, ecyc); end
        total++; if (ae !== 1'b1) begin bad++; $display("FAIL data_nack_ack_err_held: got %b want 1", ae); end
        total++; if (sig !== esig || n !== en) begin
            bad++; $display("FAIL data_nack_wire: got %h/%0d want %h/%0d", sig, n, esig, en);
        end
        do_write(d2, d1, d0, -1, 1'b0, lat, bc, dn, aa, ae, sig, n);
        total++; if (aa !== 1'b0) begin bad++; $display("FAIL ack_err_clear_on_accept: got %b want 0", aa); end
        total++; if (ae !== 1'b0) begin bad++; $display("FAIL ack_err_after_good: got %b want 0", ae); end
    endtask

    task automatic test_start_while_busy();
        int lat, bc, dn, n, en, ecyc;
        logic aa, ae;
        logic [63:0] sig, esig;
        logic [7:0] d0, d1, d2;
        d0 = 8'($urandom); d1 = 8'($urandom); d2 = 8'($urandom);
        do_write(d0, d1, d2, -1, 1'b1, lat, bc, dn, aa, ae, sig, n);
        model_frame(d0, d1, d2, -1, esig, en, ecyc);
        total++; if (dn !== 1) begin bad++; $display("FAIL busy_start_done_count: got %0d want 1", dn); end
        total++; if (lat !== ecyc) begin bad++; $display("FAIL busy_start_latency: got %0d want %0d", lat, ecyc); end
        total++; if (sig !== esig || n !== en) begin
            bad++; $display("FAIL busy_start_wire: got %h/%0d want %h/%0d", sig, n, esig, en);
        end
    endtask

    task automatic test_reset_mid_byte();
        int lat, bc, dn, n, en, ecyc, base;
        logic aa, ae;
        logic [63:0] sig, esig;
        nack_byte = -1;
        @(negedge clk);
        base = wire_log.size();
        device_addr = 8'hA4; reg_addr = 8'h5B; reg_data = 8'h3C;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // Lands inside the reg_addr byte (quarters 38..73).
        repeat ((2 + 36 + 14) * D) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        total++; if (scl_oe !== 1'b0 || sda_oe !== 1'b0) begin
            bad++; $display("FAIL midrst_bus: got scl_oe=%b sda_oe=%b want 0 0", scl_oe, sda_oe);
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        total++; if (wire_log.size() - base !== 2) begin
            bad++; $display("FAIL midrst_no_stop: got %0d wire events want 2", wire_log.size() - base);
        end
        do_write(8'hA4, 8'h5B, 8'h3C, -1, 1'b0, lat, bc, dn, aa, ae, sig, n);
        model_frame(8'hA4, 8'h5B, 8'h3C, -1, esig, en, ecyc);
        total++; if (lat !== ecyc) begin bad++; $display("FAIL after_rst_latency: got %0d want %0d", lat, ecyc); end
        total++; if (sig !== esig || n !== en) begin
            bad++; $display("FAIL after_rst_wire: got %h/%0d want %h/%0d", sig, n, esig, en);
        end
    endtask

    task automatic test_random();
        int lat, bc, dn, n, en, ecyc, nk;
        logic aa, ae;
        logic [63:0] sig, esig;
        logic [7:0] d0, d1, d2;
        for (int t = 0; t < 6; t++) begin
            d0 = 8'($urandom); d1 = 8'($urandom); d2 = 8'($urandom);
            nk = int'($urandom_range(0, 3)) - 1;
            do_write(d0, d1, d2, nk, 1'b0, lat, bc, dn, aa, ae, sig, n);
            model_frame(d0, d1, d2, nk, esig, en, ecyc);
            total++; if (lat !== ecyc) begin bad++; $display("FAIL rand%0d_latency: got %0d want %0d", t, lat, ecyc); end
            total++; if (ae !== (nk >= 0)) begin bad++; $display("FAIL rand%0d_ack_err: got %b want %b", t, ae, nk >= 0); end
            total++; if (sig !== esig || n !== en) begin
                bad++; $display("FAIL rand%0d_wire: got %h/%0d want %h/%0d", t, sig, n, esig, en);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc, dn, n, en, ecyc, dones_total;
        logic aa, ae;
        logic [63:0] sig, esig;
        logic [7:0] tbl [24][3];
        for (int i = 0; i < 24; i++)
            for (int j = 0; j < 3; j++) tbl[i][j] = 8'($urandom);
        dones_total = 0;
        for (int i = 0; i < 24; i++) begin
            do_write(tbl[i][0], tbl[i][1], tbl[i][2], -1, 1'b0, lat, bc, dn, aa, ae, sig, n);
            model_frame(tbl[i][0], tbl[i][1], tbl[i][2], -1, esig, en, ecyc);
            dones_total += dn;
            total++; if (sig !== esig || n !== en || lat !== ecyc) begin
                bad++; $display("FAIL seq%0d: got %h/%0d lat %0d want %h/%0d lat %0d", i, sig, n, lat, esig, en, ecyc);
            end
        end
        total++; if (dones_total !== 24) begin bad++; $display("FAIL seq_all_done: got %0d done pulses want 24", dones_total); end
    endtask

    initial begin
        test_reset();
        test_write_path();
        test_device_nack();
        test_data_nack();
        test_start_while_busy();
        test_reset_mid_byte();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
